cnt_step_ctrl: RTL and testbench
================================

# cnt_step_ctrl

Command controller that sits between the raw `ui_in` push-button requests (up, down, hold) and the 8-bit up/down counter datapath. It synchronizes and debounces the requests and arbitrates conflicts. It emits single-cycle step commands, an optional auto-repeat stream, a freeze level and a synchronous load command. The counter itself only sees clean, mutually exclusive, one-cycle controls.

## Interface
Parameters:
- `DEB_CYCLES`, 4: consecutive stable synchronized samples required to accept a button level (1..255).
- `REPEAT_DELAY`, 16: cycles a step button must stay held after its first step before auto-repeat begins.
- `REPEAT_PERIOD`, 4: cycles between auto-repeat steps (≥2).
- `W`, 8: width of load value.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `up_req`  in  1  raw up button (asynchronous to clk).
- `down_req`  in  1  raw down button (asynchronous).
- `hold_req`  in  1  raw hold button (asynchronous).
- `load_req`  in  1  synchronous one-cycle load strobe from on-chip logic.
- `load_val`  in  W  value to load, sampled with `load_req`.
- `cnt_step`  out  1  one-cycle step command to counter.
- `cnt_dir`  out  1  direction qualifying `cnt_step`: 1 = up, 0 = down.
- `cnt_load`  out  1  one-cycle load command.
- `cnt_load_val`  out  W  registered load value, valid with `cnt_load`.
- `cnt_freeze`  out  1  level: counter must hold its value.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Each raw button passes through a 2-flop synchronizer and then a debouncer. The debounced level changes only after `DEB_CYCLES` consecutive identical synchronized samples.
- Command code from the debounced levels: up only → UP; down only → DOWN; both → CONFLICT; neither → NONE.
- Priority: hold > load > step.
- FSM states:
  - IDLE: command UP/DOWN → FIRE. CONFLICT and NONE → stay.
  - FIRE: `cnt_step` = 1 for one cycle, `cnt_dir` per the latched command → WAIT_REL.
  - WAIT_REL: leaves on release (NONE) → IDLE. A command change to CONFLICT or to the opposite direction → IDLE, with no step. With auto-repeat, the held delay reaching `REPEAT_DELAY` → REPEAT.
  - REPEAT: emits a step every `REPEAT_PERIOD` cycles. Release or a command change → IDLE.
  - FROZEN: entered from any state when debounced hold = 1. `cnt_freeze` = 1 and no steps are issued. On hold release: → WAIT_REL (no new step) if UP/DOWN is still asserted, else → IDLE.
- Load: `load_req` registers `load_val` and asserts `cnt_load` the next cycle, except in FROZEN, where it is dropped.
  - If a step would be issued in the same cycle as `cnt_load`, the step is discarded, the FSM continues as if the step had been issued, and the repeat timer restarts.
- `cnt_step` and `cnt_load` are never high together.
- Timers are saturating counters of width `$clog2(max+1)`. They clear on every state entry.

## Timing
- Reset (asynchronous assert, synchronous deassert internal): all outputs 0, state IDLE, synchronizers, debouncers and timers cleared, debounced levels 0.
- Step latency: first edge sampling a stable `up_req` = 1 is edge 0. The debounced level rises after edge `DEB_CYCLES+1`. FIRE is entered at edge `DEB_CYCLES+2`. `cnt_step` is high during the cycle following edge `DEB_CYCLES+2` (6 edges at default).
- Auto-repeat: the first repeat step comes `REPEAT_DELAY` cycles after the FIRE pulse, then every `REPEAT_PERIOD` cycles.
- Load latency: 1 cycle.
- Freeze latency from raw hold: `DEB_CYCLES+2` edges. Release follows the same latency.
- A reset asserted mid-pulse truncates the pulse immediately.
- All outputs are registered.

## Configuration
- `CNT_STEP_CTRL_AUTOREPEAT_EN` defined: the REPEAT state and repeat timer are present.
- Undefined: the REPEAT state and timer are absent. WAIT_REL waits only for release or a command change, and exactly one step is issued per press.

## Structure
- Package `cnt_step_ctrl_pkg`: state enum typedef (IDLE, FIRE, WAIT_REL, REPEAT, FROZEN), command typedef (NONE, UP, DOWN, CONFLICT), default parameter constants.
- Sub-module `cnt_step_debounce` (synchronizer + debouncer, parameter `DEB_CYCLES`), instantiated three times.

## Test plan
- `up_req` held 40 cycles at defaults, macro off → exactly one `cnt_step`, `cnt_dir` = 1, 6 edges after assertion.
- Macro on, `down_req` held 40 cycles → steps with `cnt_dir` = 0 at t0, t0+16, t0+20, t0+24 ….
- `up_req` and `down_req` both held → no `cnt_step`. Release `down_req` only → no step until `up_req` is released and re-pressed.
- Bounce: `up_req` toggles every 2 cycles for 20 cycles, then stays high → a single step, timed from the last edge.
- `hold_req` high, then `load_req` with `load_val` = 8'h5A and `up_req` pressed → `cnt_freeze` = 1, no load, no step. Hold released while up still held → no step.
- `load_req` (8'hA3) in the cycle a step would fire → `cnt_load` = 1 with 8'hA3, `cnt_step` = 0. Async reset mid-REPEAT → all outputs 0 immediately.

Source files
------------

// File: rtl/cnt_step_ctrl_pkg.sv
// Shared types and defaults for the counter step controller.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package cnt_step_ctrl_pkg;

    localparam int DEF_DEB_CYCLES    = 4;
    localparam int DEF_REPEAT_DELAY  = 16;
    localparam int DEF_REPEAT_PERIOD = 4;
    localparam int DEF_W             = 8;

    // Controller states, kept as plain constants for legacy tool flows.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_FIRE     = 3'd1;
    localparam state_t ST_WAIT_REL = 3'd2;
    localparam state_t ST_REPEAT   = 3'd3;
    localparam state_t ST_FROZEN   = 3'd4;

    // Command decoded from the debounced up/down levels.
    typedef enum logic [1:0] {
        CMD_NONE     = 2'd0,
        CMD_UP       = 2'd1,
        CMD_DOWN     = 2'd2,
        CMD_CONFLICT = 2'd3
    } cmd_e;

    function automatic cmd_e cmd_decode(input logic up, input logic down);
        cmd_e c;
        case ({down, up})
            2'b01:   c = CMD_UP;
            2'b10:   c = CMD_DOWN;
            2'b11:   c = CMD_CONFLICT;
            default: c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cnt_step_debounce.sv
// Two-flop synchronizer followed by a run-length debouncer for one raw button.
// Latency: level follows a stable raw input DEB_CYCLES+2 edges after the first sampling edge.
// Backpressure: none; free-running.
// Ports: clk, rst_n (async active-low), raw (asynchronous button), level (debounced output).
module cnt_step_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] run;

    // run counts consecutive synchronized samples that disagree with the
    // current level; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            run    <= '0;
            level  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (sync_b == level) begin
                run <= '0;
            end else if (run == CW'(DEB_CYCLES - 1)) begin
                level <= sync_b;
                run   <= '0;
            end else begin
                run <= run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_step_ctrl.sv
// Turns raw up/down/hold buttons plus a load strobe into clean one-cycle counter controls.
// Latency: step DEB_CYCLES+2 edges after raw press, load 1 cycle, freeze DEB_CYCLES+2 edges.
// Backpressure: none; a load coinciding with a step wins and the step is discarded.
// Ports: clk, rst_n (async active-low); up_req/down_req/hold_req raw buttons; load_req/load_val
// on-chip load strobe; cnt_step/cnt_dir/cnt_load/cnt_load_val/cnt_freeze counter controls; busy.
// Option: define CNT_STEP_CTRL_AUTOREPEAT_EN to add the auto-repeat state and timer.
module cnt_step_ctrl
    import cnt_step_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int W             = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_req,
    input  logic         down_req,
    input  logic         hold_req,
    input  logic         load_req,
    input  logic [W-1:0] load_val,
    output logic         cnt_step,
    output logic         cnt_dir,
    output logic         cnt_load,
    output logic [W-1:0] cnt_load_val,
    output logic         cnt_freeze,
    output logic         busy
);

    logic   up_lvl;
    logic   down_lvl;
    logic   hold_lvl;
    cmd_e   cmd;
    cmd_e   held_cmd;
    state_t state;
    state_t state_nxt;
    logic   dir_q;
    logic   dir_nxt;
    logic   step_nxt;
    logic   armed;
    logic   load_go;

    cnt_step_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk(clk), .rst_n(rst_n), .raw(up_req), .level(up_lvl)
    );
    cnt_step_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
        .clk(clk), .rst_n(rst_n), .raw(down_req), .level(down_lvl)
    );
    cnt_step_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_hold (
        .clk(clk), .rst_n(rst_n), .raw(hold_req), .level(hold_lvl)
    );

    assign cmd      = cmd_decode(up_lvl, down_lvl);
    assign held_cmd = dir_q ? CMD_UP : CMD_DOWN;

    // Loads are dropped while frozen, including the cycle entering and the
    // cycle leaving the frozen state.
    assign load_go = load_req && !hold_lvl && (state != ST_FROZEN);

`ifdef CNT_STEP_CTRL_AUTOREPEAT_EN
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW      = $clog2(TMR_MAX + 1);
    // The FIRE cycle and the WAIT_REL entry edge account for two cycles of
    // the hold delay, so the first repeat fires REPEAT_DELAY after the FIRE pulse.
    localparam int RPT_ARM = (REPEAT_DELAY >= 2) ? REPEAT_DELAY - 2 : 0;

    logic [TW-1:0] tmr;
    logic          tmr_clr;
`else
    // Repeat timing has no effect without auto-repeat.
    logic unused_cfg;
    assign unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_q;
        step_nxt  = 1'b0;
`ifdef CNT_STEP_CTRL_AUTOREPEAT_EN
        tmr_clr   = 1'b0;
`endif
        if (hold_lvl) begin
            state_nxt = ST_FROZEN;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Only a fresh press fires: after a conflict or a direction
                    // flip the buttons must be fully released first.
                    if (armed && (cmd == CMD_UP || cmd == CMD_DOWN)) begin
                        state_nxt = ST_FIRE;
                        dir_nxt   = (cmd == CMD_UP);
                        step_nxt  = 1'b1;
                    end
                end
                ST_FIRE: begin
                    state_nxt = ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    if (cmd != held_cmd) begin
                        state_nxt = ST_IDLE;
                    end
`ifdef CNT_STEP_CTRL_AUTOREPEAT_EN
                    else if (tmr == TW'(RPT_ARM)) begin
                        state_nxt = ST_REPEAT;
                        step_nxt  = 1'b1;
                    end
`endif
                end
`ifdef CNT_STEP_CTRL_AUTOREPEAT_EN
                ST_REPEAT: begin
                    if (cmd != held_cmd) begin
                        state_nxt = ST_IDLE;
                    end else if (tmr == TW'(REPEAT_PERIOD - 1)) begin
                        step_nxt = 1'b1;
                        tmr_clr  = 1'b1;
                    end
                end
`endif
                ST_FROZEN: begin
                    if (cmd == CMD_UP || cmd == CMD_DOWN) begin
                        state_nxt = ST_WAIT_REL;
                        dir_nxt   = (cmd == CMD_UP);
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

`ifdef CNT_STEP_CTRL_AUTOREPEAT_EN
    // Saturating; restarts on every state change and after each repeat step
    // (including one swallowed by a coincident load).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr <= '0;
        end else if (state_nxt != state || tmr_clr) begin
            tmr <= '0;
        end else if (tmr != TW'(TMR_MAX)) begin
            tmr <= tmr + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            dir_q        <= 1'b0;
            armed        <= 1'b0;
            cnt_step     <= 1'b0;
            cnt_dir      <= 1'b0;
            cnt_load     <= 1'b0;
            cnt_load_val <= '0;
            cnt_freeze   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state <= state_nxt;
            dir_q <= dir_nxt;
            if (state_nxt != ST_IDLE || cmd == CMD_CONFLICT) begin
                armed <= 1'b0;
            end else if (cmd == CMD_NONE) begin
                armed <= 1'b1;
            end
            cnt_step   <= step_nxt && !load_go;
            cnt_dir    <= step_nxt && !load_go && dir_nxt;
            cnt_load   <= load_go;
            if (load_go) begin
                cnt_load_val <= load_val;
            end
            cnt_freeze <= (state_nxt == ST_FROZEN);
            busy       <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_cnt_step_ctrl.sv
// Scoreboard bench for cnt_step_ctrl: expected step/load events are queued as
// stimulus is driven and matched against the DUT outputs on the falling edge.
module tb_cnt_step_ctrl;

    localparam int DEB  = 4;
    localparam int RDLY = 16;
    localparam int RPER = 4;
    localparam int LAT  = DEB + 3;  // drive after edge c -> output seen in cycle c+LAT

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       up_req   = 1'b0;
    logic       down_req = 1'b0;
    logic       hold_req = 1'b0;
    logic       load_req = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       cnt_step;
    logic       cnt_dir;
    logic       cnt_load;
    logic [7:0] cnt_load_val;
    logic       cnt_freeze;
    logic       busy;

    typedef struct {
        int         cyc;
        bit         is_load;
        logic [7:0] val;
    } ev_t;

    ev_t sb[$];
    ev_t mon_ev;
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_errors = 0;

    cnt_step_ctrl #(
        .DEB_CYCLES(DEB), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER), .W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .up_req(up_req), .down_req(down_req), .hold_req(hold_req),
        .load_req(load_req), .load_val(load_val),
        .cnt_step(cnt_step), .cnt_dir(cnt_dir),
        .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
        .cnt_freeze(cnt_freeze), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected events for a press driven after edge c and released after edge r.
    task automatic push_press(input int c, input int r, input bit dir,
                              input bit load_first, input logic [7:0] lv);
        ev_t e;
        e.cyc     = c + LAT;
        e.is_load = load_first;
        e.val     = load_first ? lv : {7'b0, dir};
        sb.push_back(e);
`ifdef CNT_STEP_CTRL_AUTOREPEAT_EN
        for (int t = c + LAT + RDLY; t <= r + DEB + 2; t += RPER) begin
            e.cyc     = t;
            e.is_load = 1'b0;
            e.val     = {7'b0, dir};
            sb.push_back(e);
        end
`endif
    endtask

    task automatic press(input bit is_up, input int hold_cycles);
        int c;
        c = cyc;
        push_press(c, c + hold_cycles, is_up, 1'b0, 8'h00);
        if (is_up) up_req = 1'b1; else down_req = 1'b1;
        tick(hold_cycles);
        up_req   = 1'b0;
        down_req = 1'b0;
        tick(20);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("sb_missed", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (cnt_step || cnt_load) begin
            chk("step_load_excl", {31'b0, cnt_step & cnt_load}, 0);
            if (sb.size() == 0) begin
                chk("sb_unexpected", {30'b0, cnt_load, cnt_step}, 0);
            end else begin
                mon_ev = sb.pop_front();
                chk("ev_cyc", cyc, mon_ev.cyc);
                chk("ev_kind", {31'b0, cnt_load}, {31'b0, mon_ev.is_load});
                if (mon_ev.is_load) chk("load_val", {24'b0, cnt_load_val}, {24'b0, mon_ev.val});
                else                chk("step_dir", {31'b0, cnt_dir}, {31'b0, mon_ev.val[0]});
            end
        end
    end

    initial begin
        int c;
        int r;
        int target;

        // Reset state.
        tick(3);
        chk("rst_step",   {31'b0, cnt_step},   0);
        chk("rst_dir",    {31'b0, cnt_dir},    0);
        chk("rst_load",   {31'b0, cnt_load},   0);
        chk("rst_lval",   {24'b0, cnt_load_val}, 0);
        chk("rst_freeze", {31'b0, cnt_freeze}, 0);
        chk("rst_busy",   {31'b0, busy},       0);
        rst_n = 1'b1;
        tick(10);

        // Single press up, then down.
        press(1'b1, 40);
        chk("idle_after_up", {31'b0, busy}, 0);
        press(1'b0, 40);
        chk("idle_after_down", {31'b0, busy}, 0);

        // Conflict: both held, then down released alone -> no step.
        up_req   = 1'b1;
        down_req = 1'b1;
        tick(30);
        chk("conflict_busy", {31'b0, busy}, 0);
        down_req = 1'b0;
        tick(30);
        chk("conflict_rel_busy", {31'b0, busy}, 0);
        up_req = 1'b0;
        tick(20);
        press(1'b1, 12);

        // Bounce: toggles every 2 cycles, then settles high.
        for (int i = 0; i < 10; i++) begin
            up_req = (i % 2 == 0);
            tick(2);
        end
        c = cyc;
        push_press(c, c + 20, 1'b1, 1'b0, 8'h00);
        up_req = 1'b1;
        tick(20);
        up_req = 1'b0;
        tick(20);

        // Freeze: load and press are ignored, release with up held gives no step.
        c = cyc;
        hold_req = 1'b1;
        tick(DEB + 2);
        chk("freeze_early", {31'b0, cnt_freeze}, 0);
        tick(1);
        chk("freeze_lat", {31'b0, cnt_freeze}, 1);
        load_val = 8'h5A;
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        up_req   = 1'b1;
        tick(15);
        chk("frozen_freeze", {31'b0, cnt_freeze}, 1);
        chk("frozen_busy",   {31'b0, busy},       1);
        r = cyc;
        hold_req = 1'b0;
        tick(DEB + 2);
        chk("unfreeze_early", {31'b0, cnt_freeze}, 1);
        tick(1);
        chk("unfreeze_lat", {31'b0, cnt_freeze}, 0);
        chk("unfreeze_busy", {31'b0, busy}, 1);
        tick(3);
        up_req = 1'b0;
        tick(20);
        chk("idle_after_freeze", {31'b0, busy}, 0);

        // Plain load in idle.
        c = cyc;
        mon_ev.cyc = c + 1; mon_ev.is_load = 1'b1; mon_ev.val = 8'h3C;
        sb.push_back(mon_ev);
        load_val = 8'h3C;
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        tick(5);

        // Load in the very cycle the first step would fire.
        c = cyc;
        push_press(c, c + 30, 1'b1, 1'b1, 8'hA3);
        up_req = 1'b1;
        tick(LAT - 1);
        load_val = 8'hA3;
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        tick(30 - LAT);
        up_req = 1'b0;
        tick(20);

        // Asynchronous reset in the middle of a step pulse.
        c = cyc;
`ifdef CNT_STEP_CTRL_AUTOREPEAT_EN
        target = c + LAT + RDLY;
`else
        target = c + LAT;
`endif
        push_press(c, target - DEB - 2, 1'b1, 1'b0, 8'h00);
        up_req = 1'b1;
        tick(target - c);
        @(negedge clk);
        #1;
        chk("pre_reset_step", {31'b0, cnt_step}, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_step",   {31'b0, cnt_step},   0);
        chk("arst_dir",    {31'b0, cnt_dir},    0);
        chk("arst_freeze", {31'b0, cnt_freeze}, 0);
        chk("arst_busy",   {31'b0, busy},       0);
        up_req = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(10);
        chk("post_reset_busy", {31'b0, busy}, 0);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
